dma_wb_arbiter: RTL and testbench

DMA_WB_ARBITER -- requirements
Module: dma_wb_arbiter

---
 rtl/dma_wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dma_wb_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_wb_arbiter.sv
// Two-master round-robin Wishbone pipelined arbiter (m0 = CPU, m1 = DMA).
// Define DMA_WB_ARB_TIMEOUT_EN to abort transfers the slave never answers.
module dma_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OUTST_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] m0_adr,
    input  logic [31:0] m0_dat_w,
    output logic [31:0] m0_dat_r,
    input  logic        m0_we,
    input  logic        m0_stb,
    input  logic        m0_cyc,
    input  logic [3:0]  m0_sel,
    output logic        m0_ack,
    output logic        m0_stall,
    output logic        m0_err,
    input  logic [29:0] m1_adr,
    input  logic [31:0] m1_dat_w,
    output logic [31:0] m1_dat_r,
    input  logic        m1_we,
    input  logic        m1_stb,
    input  logic        m1_cyc,
    input  logic [3:0]  m1_sel,
    output logic        m1_ack,
    output logic        m1_stall,
    output logic        m1_err,
    output logic [29:0] s_adr,
    output logic [31:0] s_dat_w,
    output logic [3:0]  s_sel,
    output logic        s_we,
    output logic        s_stb,
    output logic        s_cyc,
    input  logic [31:0] s_dat_r,
    input  logic        s_ack,
    input  logic        s_stall,
    input  logic        s_err,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    state_t             state, state_nxt;
    logic               last_own, last_own_nxt;
    logic [OUTST_W-1:0] outst, outst_nxt, pend;
    logic [OUTST_W:0]   drop, drop_nxt;
    logic               own0, own1, full, rsp, route;
    logic               acc, leave, tmo_hit;

    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign grant = state;
    assign full  = (outst == OUTST_MAX);
    assign rsp   = s_ack | s_err;
    // Responses owed to a master that already left are swallowed first.
    assign route = (drop == '0);
    assign leave = (own0 & ~m0_cyc) | (own1 & ~m1_cyc);

    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_stb   = 1'b0;
        s_cyc   = 1'b0;
        if (own0) begin
            s_adr   = m0_adr;
            s_dat_w = m0_dat_w;
            s_sel   = m0_sel;
            s_we    = m0_we;
            s_stb   = m0_stb & ~full;
            s_cyc   = m0_cyc;
        end else if (own1) begin
            s_adr   = m1_adr;
            s_dat_w = m1_dat_w;
            s_sel   = m1_sel;
            s_we    = m1_we;
            s_stb   = m1_stb & ~full;
            s_cyc   = m1_cyc;
        end
    end

    assign acc = s_cyc & s_stb & ~s_stall;

    assign m0_dat_r = own0 ? s_dat_r : '0;
    assign m0_ack   = own0 & route & s_ack;
    assign m0_err   = own0 & ((route & s_err) | tmo_hit);
    assign m0_stall = ~own0 | s_stall | full;

    assign m1_dat_r = own1 ? s_dat_r : '0;
    assign m1_ack   = own1 & route & s_ack;
    assign m1_err   = own1 & ((route & s_err) | tmo_hit);
    assign m1_stall = ~own1 | s_stall | full;

`ifdef DMA_WB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_run;

    assign tmo_run = (own0 | own1) & (outst != '0) & ~rsp;
    assign tmo_hit = tmo_run &
                     (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (tmo_run && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        last_own_nxt = last_own;
        outst_nxt    = outst;
        drop_nxt     = drop;
        pend         = outst;
        if (!route && rsp)
            drop_nxt = drop - 1'b1;
        unique case (state)
            IDLE: begin
                outst_nxt = '0;
                if (m0_cyc && m1_cyc)
                    state_nxt = last_own ? OWN0 : OWN1;
                else if (m0_cyc)
                    state_nxt = OWN0;
                else if (m1_cyc)
                    state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (acc && !(route && rsp))
                    pend = outst + 1'b1;
                else if (!acc && route && rsp && outst != '0)
                    pend = outst - 1'b1;
                outst_nxt = pend;
                if (leave || tmo_hit) begin
                    state_nxt    = IDLE;
                    last_own_nxt = own1;
                    outst_nxt    = '0;
                    // A timed-out slave may never answer, so owe it nothing.
                    if (!tmo_hit)
                        drop_nxt = drop_nxt + {1'b0, pend};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_own <= 1'b0;
            outst    <= '0;
            drop     <= '0;
        end else begin
            state    <= state_nxt;
            last_own <= last_own_nxt;
            outst    <= outst_nxt;
            drop     <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_dma_wb_arbiter.sv
// Bench for dma_wb_arbiter: routing vector table plus a slave model
// with response scoreboards for bursts, stale acks, limits and reset.
module tb_dma_wb_arbiter;

    localparam int TMO = 8;
    localparam logic [29:0] A0 = 30'h0000123;
    localparam logic [29:0] A1 = 30'h0000456;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] m0_adr, m1_adr, s_adr;
    logic [31:0] m0_dat_w, m1_dat_w, s_dat_w;
    logic [31:0] m0_dat_r, m1_dat_r, s_dat_r;
    logic        m0_we, m0_stb, m0_cyc;
    logic        m1_we, m1_stb, m1_cyc;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic        m0_ack, m0_stall, m0_err;
    logic        m1_ack, m1_stall, m1_err;
    logic        s_we, s_stb, s_cyc;
    logic        s_ack, s_stall, s_err;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    dma_wb_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .OUTST_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_we(m0_we), .m0_stb(m0_stb), .m0_cyc(m0_cyc),
        .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_we(m1_we), .m1_stb(m1_stb), .m1_cyc(m1_cyc),
        .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall),
        .s_err(s_err), .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bad(string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, required none", name);
    endtask

    function automatic logic [31:0] rdata(logic [29:0] a);
        return 32'hDEADBEEF ^ {2'b00, a};
    endfunction

    function automatic logic [31:0] wdata(logic [29:0] a);
        return {2'b10, a} ^ 32'h0F0F0000;
    endfunction

    typedef struct packed {
        logic        rd;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        logic       m0c, m0s, m1c, m1s, ack, stl, err;
        logic [1:0] g;
        logic       cyc, stb, a0, a1, st0, st1, e0, e1;
    } vec_t;

    // slave model and scoreboards
    exp_t        q0[$], q1[$];
    logic [31:0] wr_exp[$];
    int          ack_at[$];
    logic [31:0] ack_dat[$];
    int          cyc_no = 0;
    int          lat = 2;
    bit          hung = 0;
    int          stall_beat = -1;
    int          stall_left = 0;
    int          beats = 0;
    int          acks0 = 0;
    int          acks1 = 0;

    logic [1:0]  sn_g;
    logic        sn_cyc, sn_a0, sn_a1, sn_e0, sn_e1;
    logic        sn_st0, sn_st1;
    logic [31:0] sn_d1;

    task automatic resp(int m, logic [31:0] d, logic e);
        exp_t x;
        if (m == 0) begin
            if (q0.size() == 0) begin
                bad("m0_rsp_unexp");
                return;
            end
            x = q0.pop_front();
            acks0++;
        end else begin
            if (q1.size() == 0) begin
                bad("m1_rsp_unexp");
                return;
            end
            x = q1.pop_front();
            acks1++;
        end
        if (x.rd && !e)
            chk($sformatf("m%0d_rdata", m), d, x.d);
    endtask

    task automatic step();
        @(negedge clk);
        sn_g   = grant;
        sn_cyc = s_cyc;
        sn_a0  = m0_ack;
        sn_a1  = m1_ack;
        sn_e0  = m0_err;
        sn_e1  = m1_err;
        sn_st0 = m0_stall;
        sn_st1 = m1_stall;
        sn_d1  = m1_dat_r;
        if (s_cyc && s_stb && !s_stall) begin
            beats++;
            if (s_we) begin
                if (wr_exp.size() == 0)
                    bad("wr_unexp");
                else
                    chk("wdata", s_dat_w, wr_exp.pop_front());
            end
            if (!hung) begin
                ack_at.push_back(cyc_no + lat);
                ack_dat.push_back(rdata(s_adr));
            end
        end
        if (m0_ack || m0_err)
            resp(0, m0_dat_r, m0_err);
        if (m1_ack || m1_err)
            resp(1, m1_dat_r, m1_err);
        @(posedge clk);
        #1;
        cyc_no++;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat_r = '0;
        if (ack_at.size() > 0 && ack_at[0] <= cyc_no) begin
            void'(ack_at.pop_front());
            s_ack   = 1'b1;
            s_dat_r = ack_dat.pop_front();
        end
        s_stall = 1'b0;
        if (stall_left > 0 && beats == stall_beat) begin
            s_stall = 1'b1;
            stall_left--;
        end
    endtask

    task automatic burst(int m, int n, bit we, logic [29:0] base);
        int          i = 0;
        int          g = 0;
        bit          pushed = 0;
        logic [29:0] a;
        exp_t        x;
        if (m == 0) m0_cyc = 1'b1;
        else        m1_cyc = 1'b1;
        while (i < n && g < 100) begin
            a = base + 30'(i);
            if (!pushed) begin
                x.rd = !we;
                x.d  = rdata(a);
                if (m == 0) q0.push_back(x);
                else        q1.push_back(x);
                if (we) wr_exp.push_back(wdata(a));
                pushed = 1;
            end
            if (m == 0) begin
                m0_stb = 1'b1; m0_adr = a; m0_we = we;
                m0_dat_w = wdata(a);
            end else begin
                m1_stb = 1'b1; m1_adr = a; m1_we = we;
                m1_dat_w = wdata(a);
            end
            step();
            if (!(m == 0 ? sn_st0 : sn_st1)) begin
                i++;
                pushed = 0;
            end
            g++;
        end
        m0_stb = 1'b0;
        m1_stb = 1'b0;
        if (g >= 100)
            bad("burst_timeout");
    endtask

    task automatic wait_acks(int m, int n);
        int g = 0;
        while ((m == 0 ? acks0 : acks1) < n && g < 60) begin
            step();
            g++;
        end
        chk($sformatf("m%0d_acks", m), m == 0 ? acks0 : acks1, n);
    endtask

    vec_t tv[13];

    initial begin
        int          ca, ce, npulse, nrsp;
        logic        cyc_after;
        logic [1:0]  g_after;
        logic [29:0] ea;

        tv[0]  = '{1,0,1,0,0,0,0, 2'b00,0,0,0,0,1,1,0,0};
        tv[1]  = '{1,0,1,1,0,0,0, 2'b10,1,1,0,0,1,0,0,0};
        tv[2]  = '{1,0,1,0,1,0,0, 2'b10,1,0,0,1,1,0,0,0};
        tv[3]  = '{1,0,0,0,0,0,0, 2'b10,0,0,0,0,1,0,0,0};
        tv[4]  = '{1,0,0,0,0,0,0, 2'b00,0,0,0,0,1,1,0,0};
        tv[5]  = '{1,1,0,0,0,0,0, 2'b01,1,1,0,0,0,1,0,0};
        tv[6]  = '{1,1,0,0,0,1,0, 2'b01,1,1,0,0,1,1,0,0};
        tv[7]  = '{1,0,1,0,1,0,0, 2'b01,1,0,1,0,0,1,0,0};
        tv[8]  = '{0,0,1,0,0,0,0, 2'b01,0,0,0,0,0,1,0,0};
        tv[9]  = '{1,0,1,0,0,0,0, 2'b00,0,0,0,0,1,1,0,0};
        tv[10] = '{1,0,1,0,0,0,1, 2'b10,1,0,0,0,1,0,0,1};
        tv[11] = '{0,0,0,0,0,0,0, 2'b10,0,0,0,0,1,0,0,0};
        tv[12] = '{0,0,0,0,0,0,0, 2'b00,0,0,0,0,1,1,0,0};

        rst_n = 1'b0;
        m0_adr = A0; m0_dat_w = 32'h11111111; m0_we = 0;
        m0_stb = 0;  m0_cyc = 0; m0_sel = 4'hF;
        m1_adr = A1; m1_dat_w = 32'h22222222; m1_we = 1;
        m1_stb = 0;  m1_cyc = 0; m1_sel = 4'h3;
        s_dat_r = 32'hCAFEF00D; s_ack = 0; s_stall = 0; s_err = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_adr", s_adr, 0);
        chk("rst_s_we", s_we, 0);
        chk("rst_m0_stall", m0_stall, 1);
        chk("rst_m1_stall", m1_stall, 1);
        chk("rst_m1_dat_r", m1_dat_r, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            m0_cyc = tv[i].m0c; m0_stb = tv[i].m0s;
            m1_cyc = tv[i].m1c; m1_stb = tv[i].m1s;
            s_ack = tv[i].ack;  s_stall = tv[i].stl;
            s_err = tv[i].err;
            @(negedge clk);
            ea = tv[i].g == 2'b01 ? A0 :
                 tv[i].g == 2'b10 ? A1 : 30'h0;
            chk($sformatf("v%0d_grant", i), grant, tv[i].g);
            chk($sformatf("v%0d_s_cyc", i), s_cyc, tv[i].cyc);
            chk($sformatf("v%0d_s_stb", i), s_stb, tv[i].stb);
            chk($sformatf("v%0d_m0_ack", i), m0_ack, tv[i].a0);
            chk($sformatf("v%0d_m1_ack", i), m1_ack, tv[i].a1);
            chk($sformatf("v%0d_m0_stall", i), m0_stall, tv[i].st0);
            chk($sformatf("v%0d_m1_stall", i), m1_stall, tv[i].st1);
            chk($sformatf("v%0d_m0_err", i), m0_err, tv[i].e0);
            chk($sformatf("v%0d_m1_err", i), m1_err, tv[i].e1);
            chk($sformatf("v%0d_s_adr", i), s_adr, ea);
            chk($sformatf("v%0d_m0_dat_r", i), m0_dat_r,
                tv[i].g == 2'b01 ? 32'hCAFEF00D : 32'h0);
            chk($sformatf("v%0d_m1_dat_r", i), m1_dat_r,
                tv[i].g == 2'b10 ? 32'hCAFEF00D : 32'h0);
            @(posedge clk);
            #1;
        end
        s_ack = 0; s_err = 0; s_stall = 0; s_dat_r = 0;

        // single m1 read, slave answers two cycles after acceptance
        lat = 2; beats = 0; acks1 = 0;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 30'h0;
        q1.push_back('{1'b1, rdata(30'h0)});
        step();
        chk("r1_s_cyc_n", sn_cyc, 0);
        chk("r1_m0_stall_n", sn_st0, 1);
        step();
        chk("r1_s_cyc_n1", sn_cyc, 1);
        chk("r1_m1_stall_n1", sn_st1, 0);
        chk("r1_m0_stall_n1", sn_st0, 1);
        m1_stb = 0;
        step();
        chk("r1_m1_ack_n2", sn_a1, 0);
        chk("r1_m0_stall_n2", sn_st0, 1);
        step();
        chk("r1_m1_ack_n3", sn_a1, 1);
        chk("r1_m1_dat_n3", sn_d1, 32'hDEADBEEF);
        chk("r1_m0_stall_n3", sn_st0, 1);
        m1_cyc = 0;
        repeat (2) step();

        // m0 write burst with one slave stall on the second beat
        beats = 0; acks0 = 0; stall_beat = 1; stall_left = 1;
        burst(0, 4, 1, 30'h40);
        wait_acks(0, 4);
        chk("wb_beats", beats, 4);
        chk("wb_wr_left", wr_exp.size(), 0);
        m0_cyc = 0;
        repeat (2) step();

        // m1 pipelined read burst
        beats = 0; acks1 = 0; lat = 3;
        burst(1, 3, 0, 30'h80);
        wait_acks(1, 3);
        chk("rb_beats", beats, 3);
        m1_cyc = 0;
        repeat (2) step();

        // m0 leaves with two reads pending; late acks land under m1
        lat = 4; acks0 = 0; acks1 = 0;
        burst(0, 2, 0, 30'h200);
        m0_cyc = 0;
        m1_cyc = 1;
        nrsp = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (sn_a1 || sn_a0) nrsp++;
        end
        chk("stale_acks_seen", nrsp, 0);
        chk("stale_m0_pending", q0.size(), 2);
        q0.delete();
        burst(1, 1, 0, 30'h300);
        wait_acks(1, 1);
        m1_cyc = 0;
        repeat (2) step();

`ifdef DMA_WB_ARB_TIMEOUT_EN
        // hung slave: error pulse TMO cycles after acceptance
        hung = 1; ca = -1; ce = -1; npulse = 0;
        cyc_after = 1'b1; g_after = 2'b11;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 30'h10;
        q0.push_back('{1'b1, 32'h0});
        for (int k = 0; k < 20; k++) begin
            step();
            if (ce >= 0 && cyc_no - 1 == ce + 1) begin
                cyc_after = sn_cyc;
                g_after = sn_g;
            end
            if (sn_e0) npulse++;
            if (ce < 0 && sn_e0) ce = cyc_no - 1;
            if (ca < 0 && !sn_st0) begin
                ca = cyc_no - 1;
                m0_stb = 0;
            end
        end
        chk("tmo_delay", ce - ca, TMO);
        chk("tmo_pulses", npulse, 1);
        chk("tmo_s_cyc_after", cyc_after, 0);
        chk("tmo_grant_after", g_after, 2'b00);
        m0_cyc = 0;
        hung = 0;
        repeat (2) step();
`else
        // hung slave: outstanding limit stops acceptance at 15
        hung = 1; beats = 0;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 30'h20;
        repeat (30) step();
        chk("sat_beats", beats, (1 << 4) - 1);
        chk("sat_m0_stall", sn_st0, 1);
        chk("sat_grant", sn_g, 2'b01);
        m0_stb = 0; m0_cyc = 0;
        hung = 0;
        repeat (2) step();
`endif

        // reset in the middle of an m1 burst
        lat = 10;
        burst(1, 3, 0, 30'h500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_grant", grant, 2'b00);
        chk("rst_mid_s_cyc", s_cyc, 0);
        chk("rst_mid_m1_stall", m1_stall, 1);
        chk("rst_mid_m1_ack", m1_ack, 0);
        m1_cyc = 0;
        ack_at.delete(); ack_dat.delete(); q0.delete(); q1.delete();
        @(posedge clk);
        #1;
        s_ack = 0; s_err = 0; s_stall = 0; s_dat_r = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (sn_a0 || sn_a1 || sn_e0 || sn_e1) nrsp++;
        end
        chk("post_rst_rsp", nrsp, 0);
        chk("post_rst_grant", sn_g, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
